car_park_occupancy: RTL

//  Consumes the two gate photo-sensor lines a/b and decodes the ordered a/b pattern into enter/exit events.

---
 rtl/car_park_pkg.sv | 31 +++
 rtl/ab_seq_detector.sv | 97 +++++++++
 rtl/car_park_occupancy.sv | 101 ++++++++++
 3 files changed

// File: rtl/car_park_pkg.sv
// Shared constants for the car park occupancy block: sensor patterns,
// detector state encoding and the default capacity.
package car_park_pkg;

    localparam int DEFAULT_CAPACITY = 15;

    // {a,b} sensor patterns; a is the outer beam, b the inner beam
    localparam logic [1:0] P_CLEAR = 2'b00;
    localparam logic [1:0] P_A     = 2'b10;
    localparam logic [1:0] P_AB    = 2'b11;
    localparam logic [1:0] P_B     = 2'b01;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EN1  = 3'd1;
    localparam logic [2:0] ST_EN2  = 3'd2;
    localparam logic [2:0] ST_EN3  = 3'd3;
    localparam logic [2:0] ST_EX1  = 3'd4;
    localparam logic [2:0] ST_EX2  = 3'd5;
    localparam logic [2:0] ST_EX3  = 3'd6;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        EN1  = ST_EN1,
        EN2  = ST_EN2,
        EN3  = ST_EN3,
        EX1  = ST_EX1,
        EX2  = ST_EX2,
        EX3  = ST_EX3
    } seq_state_e;

endpackage

// File: rtl/ab_seq_detector.sv
// Decodes the ordered a/b beam pattern of a passing car into single-cycle
// enter/exit/seq_err strobes (combinational, aligned with the sampling edge).
module ab_seq_detector
    import car_park_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic enter_evt,
    output logic exit_evt,
    output logic seq_err
);

    seq_state_e state_q;
    seq_state_e state_d;
    logic [1:0] ab;

    assign ab = {a, b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Matching the current pattern holds; stepping one stage either way is
    // legal; a clear beam mid-path means the car backed out; anything else is a jump.
    always_comb begin
        state_d   = state_q;
        enter_evt = 1'b0;
        exit_evt  = 1'b0;
        seq_err   = 1'b0;
        unique case (state_q)
            IDLE: begin
                case (ab)
                    P_A:     state_d = EN1;
                    P_B:     state_d = EX1;
                    P_AB:    seq_err = 1'b1;
                    default: state_d = IDLE;
                endcase
            end
            EN1: begin
                case (ab)
                    P_AB:    state_d = EN2;
                    P_CLEAR: state_d = IDLE;
                    P_B:     begin state_d = IDLE; seq_err = 1'b1; end
                    default: state_d = EN1;
                endcase
            end
            EN2: begin
                case (ab)
                    P_B:     state_d = EN3;
                    P_A:     state_d = EN1;
                    P_CLEAR: state_d = IDLE;
                    default: state_d = EN2;
                endcase
            end
            EN3: begin
                case (ab)
                    P_CLEAR: begin state_d = IDLE; enter_evt = 1'b1; end
                    P_AB:    state_d = EN2;
                    P_A:     begin state_d = IDLE; seq_err = 1'b1; end
                    default: state_d = EN3;
                endcase
            end
            EX1: begin
                case (ab)
                    P_AB:    state_d = EX2;
                    P_CLEAR: state_d = IDLE;
                    P_A:     begin state_d = IDLE; seq_err = 1'b1; end
                    default: state_d = EX1;
                endcase
            end
            EX2: begin
                case (ab)
                    P_A:     state_d = EX3;
                    P_B:     state_d = EX1;
                    P_CLEAR: state_d = IDLE;
                    default: state_d = EX2;
                endcase
            end
            EX3: begin
                case (ab)
                    P_CLEAR: begin state_d = IDLE; exit_evt = 1'b1; end
                    P_AB:    state_d = EX2;
                    P_B:     begin state_d = IDLE; seq_err = 1'b1; end
                    default: state_d = EX3;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/car_park_occupancy.sv
// Car park occupancy tracker: turns detector events into a saturating count
// with registered full/empty flags and one-cycle event/error pulses.
module car_park_occupancy
    import car_park_pkg::*;
#(
    parameter  int CAPACITY = DEFAULT_CAPACITY,
    localparam int COUNT_W  = (CAPACITY > 0) ? $clog2(CAPACITY + 1) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a,
    input  logic               b,
    output logic               inc,
    output logic               dec,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty,
    output logic               over_err,
    output logic               under_err,
    output logic               seq_err
);

    localparam logic [COUNT_W-1:0] CAP_C = COUNT_W'(CAPACITY);

    logic enter_evt;
    logic exit_evt;
    logic seq_evt;

    logic [COUNT_W-1:0] count_q, count_d;
    logic inc_q, inc_d, dec_q, dec_d;
    logic over_q, over_d, under_q, under_d;
    logic seq_q, full_q, full_d, empty_q, empty_d;

    ab_seq_detector u_detector (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .enter_evt (enter_evt),
        .exit_evt  (exit_evt),
        .seq_err   (seq_evt)
    );

    // Flags are derived from the next count so they agree with count in the same cycle.
    always_comb begin
        count_d = count_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        over_d  = 1'b0;
        under_d = 1'b0;
        if (enter_evt) begin
            if (count_q < CAP_C) begin
                count_d = count_q + COUNT_W'(1);
                inc_d   = 1'b1;
            end else begin
                over_d  = 1'b1;
            end
        end else if (exit_evt) begin
            if (count_q != '0) begin
                count_d = count_q - COUNT_W'(1);
                dec_d   = 1'b1;
            end else begin
                under_d = 1'b1;
            end
        end
        full_d  = (count_d == CAP_C);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            over_q  <= 1'b0;
            under_q <= 1'b0;
            seq_q   <= 1'b0;
            full_q  <= (CAPACITY == 0);
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            over_q  <= over_d;
            under_q <= under_d;
            seq_q   <= seq_evt;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign count     = count_q;
    assign inc       = inc_q;
    assign dec       = dec_q;
    assign over_err  = over_q;
    assign under_err = under_q;
    assign seq_err   = seq_q;
    assign full      = full_q;
    assign empty     = empty_q;

endmodule
